sha256_round_engine: RTL and testbench

SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

---
 rtl/sha256_pkg.sv | 46 ++++
 rtl/sha256_round.sv | 27 ++
 rtl/sha256_round_engine.sv | 140 ++++++++++++++
 tb/tb_sha256_round_engine.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, compression helper functions,
// state-word bundle and the engine FSM encoding.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned MAX_RNDS  = 64;

  typedef logic [WORD_W-1:0] word_t;
  // Index 0 is A, index 7 is H.
  typedef word_t [NUM_WORDS-1:0] state_words_t;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_OUT} fsm_state_t;

  localparam word_t K [MAX_RNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round over the eight working words.
module sha256_round
  import sha256_pkg::*;
(
  input  state_words_t st_i,
  input  word_t        k_i,
  input  word_t        w_i,
  output state_words_t st_c_o
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    t2 = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
    st_c_o[0] = t1 + t2;
    st_c_o[1] = st_i[0];
    st_c_o[2] = st_i[1];
    st_c_o[3] = st_i[2];
    st_c_o[4] = st_i[3] + t1;
    st_c_o[5] = st_i[4];
    st_c_o[6] = st_i[5];
    st_c_o[7] = st_i[6];
  end

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: serial state load, UNROLL rounds per clock,
// serial result unload with optional feed-forward of the loaded state.
module sha256_round_engine
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS      = 64,
  parameter int unsigned UNROLL      = 1,
  parameter int unsigned FEEDFORWARD = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_var,
  input  logic [32*UNROLL-1:0] in_w,
  output logic                 w_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_var,
  output logic                 busy
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned IDX_W = 3;
  localparam bit PARAMS_OK = (ROUNDS >= 1) && (ROUNDS <= MAX_RNDS) &&
                             ((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4)) &&
                             ((ROUNDS % UNROLL) == 0) && (FEEDFORWARD <= 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("sha256_round_engine: illegal ROUNDS/UNROLL/FEEDFORWARD combination");
  end

  fsm_state_t   state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] r_q, r_d;
  state_words_t work_q, work_d;
  state_words_t saved_q, saved_d;
  logic         in_ready_q, in_ready_d;
  logic         w_ready_q, w_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  word_t        out_var_q, out_var_d;
  logic [CNT_W-1:0] r_step;

  // Round chain: lane gi consumes K[r+gi] and W[r+gi].
  state_words_t chain [UNROLL+1];
  assign chain[0] = work_q;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
    sha256_round u_round (
      .st_i   (chain[gi]),
      .k_i    (K[6'(r_q + CNT_W'(gi))]),
      .w_i    (in_w[32*gi +: 32]),
      .st_c_o (chain[gi+1])
    );
  end

  assign r_step = r_q + CNT_W'(UNROLL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    r_d     = r_q;
    work_d  = work_q;
    saved_d = saved_q;
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          work_d[idx_q]  = in_var;
          saved_d[idx_q] = in_var;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
            state_d = ST_RUN;
            r_d     = '0;
          end
        end
      end
      ST_RUN: begin
        work_d = chain[UNROLL];
        r_d    = r_step;
        if (r_step == CNT_W'(ROUNDS)) begin
          state_d = ST_OUT;
          idx_d   = '0;
        end
      end
      ST_OUT: begin
        if (out_valid_q && out_ready) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Outputs are registered copies of what the next state presents.
    in_ready_d  = (state_d == ST_LOAD);
    w_ready_d   = (state_d == ST_RUN);
    out_valid_d = (state_d == ST_OUT);
    busy_d      = (state_d != ST_LOAD);
    out_var_d   = '0;
    if (state_d == ST_OUT) begin
      out_var_d = (FEEDFORWARD != 0) ? work_d[idx_d] + saved_d[idx_d] : work_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      r_q         <= '0;
      work_q      <= '0;
      saved_q     <= '0;
      in_ready_q  <= 1'b0;
      w_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_var_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      r_q         <= r_d;
      work_q      <= work_d;
      saved_q     <= saved_d;
      in_ready_q  <= in_ready_d;
      w_ready_q   <= w_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_var_q   <= out_var_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign w_ready   = w_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_var   = out_var_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Bench for sha256_round_engine: four configurations checked against known
// digests and a plain-arithmetic SHA-256 compression model.
module tb_sha256_round_engine;

  localparam int CFG_ROUNDS [4] = '{64, 64, 64, 1};
  localparam int CFG_UNROLL [4] = '{1, 2, 4, 1};
  localparam int CFG_FF     [4] = '{1, 1, 1, 0};

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] ABC_DIGEST [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [31:0] ONE_ROUND [8] = '{
    32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
    32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};

  localparam logic [31:0] TB_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic        clk;
  logic        reset;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [31:0] in_var    [4];
  logic [127:0] in_w     [4];
  logic        w_ready   [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] out_var   [4];
  logic        busy      [4];

  int errors = 0;
  int checks = 0;

  sha256_round_engine #(.ROUNDS(64), .UNROLL(1), .FEEDFORWARD(1)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_var(in_var[0]),
    .in_w(in_w[0][31:0]), .w_ready(w_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_var(out_var[0]), .busy(busy[0]));
  sha256_round_engine #(.ROUNDS(64), .UNROLL(2), .FEEDFORWARD(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_var(in_var[1]),
    .in_w(in_w[1][63:0]), .w_ready(w_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_var(out_var[1]), .busy(busy[1]));
  sha256_round_engine #(.ROUNDS(64), .UNROLL(4), .FEEDFORWARD(1)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_var(in_var[2]),
    .in_w(in_w[2][127:0]), .w_ready(w_ready[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_var(out_var[2]), .busy(busy[2]));
  sha256_round_engine #(.ROUNDS(1), .UNROLL(1), .FEEDFORWARD(0)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_var(in_var[3]),
    .in_w(in_w[3][31:0]), .w_ready(w_ready[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_var(out_var[3]), .busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference compression: plain loop over rounds on an eight-word vector.
  function automatic void ref_compress(input logic [31:0] iv[8], input logic [31:0] w[64],
                                       input int rounds, input int ff, output logic [31:0] res[8]);
    logic [31:0] v[8];
    logic [31:0] t1, t2;
    for (int i = 0; i < 8; i++) v[i] = iv[i];
    for (int t = 0; t < rounds; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + TB_K[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[0] = t1 + t2;
      v[4] = v[4] + t1;
    end
    for (int i = 0; i < 8; i++) res[i] = (ff != 0) ? v[i] + iv[i] : v[i];
  endfunction

  // Message schedule of the single padded block for "abc".
  function automatic void abc_sched(output logic [31:0] w[64]);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w[t] = 32'h0;
    w[0]  = 32'h61626380;
    w[15] = 32'h00000018;
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
  endfunction

  // Drives one block through engine sel; returns observed words and protocol counters.
  task automatic run_block(input int sel, input logic [31:0] iv[8], input logic [31:0] w[64],
                           input int gap, input int stall_word, input int stall_cycles, input int abort_after,
                           output logic [31:0] res[8], output int run_cycles, output int proto_errs,
                           output int stall_changes, output int timeouts);
    int n;
    logic [31:0] held;
    run_cycles = 0; proto_errs = 0; stall_changes = 0; timeouts = 0;
    for (int k = 0; k < 8; k++) res[k] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_var[sel] = $urandom;
          if (in_ready[sel] !== 1'b1 || busy[sel] !== 1'b0) proto_errs++;
          @(posedge clk); #1;
        end
      end
      in_valid[sel] = 1'b1;
      in_var[sel]   = iv[i];
      n = 0;
      while (in_ready[sel] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) timeouts++;
      if (w_ready[sel] !== 1'b0 || out_valid[sel] !== 1'b0) proto_errs++;
      @(posedge clk); #1;
      in_valid[sel] = 1'b0;
      in_var[sel]   = $urandom;
    end
    n = 0;
    while (w_ready[sel] === 1'b1 && n < 200) begin
      if (abort_after > 0 && run_cycles == abort_after) return;
      if (busy[sel] !== 1'b1 || in_ready[sel] !== 1'b0 || out_valid[sel] !== 1'b0) proto_errs++;
      in_valid[sel] = $urandom_range(0, 1);
      for (int l = 0; l < CFG_UNROLL[sel]; l++) in_w[sel][32*l +: 32] = w[run_cycles*CFG_UNROLL[sel] + l];
      @(posedge clk); #1;
      run_cycles++;
      n++;
    end
    if (n >= 200) timeouts++;
    in_valid[sel] = 1'b0;
    in_w[sel] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (out_valid[sel] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin timeouts++; break; end
      if (busy[sel] !== 1'b1 || in_ready[sel] !== 1'b0 || w_ready[sel] !== 1'b0) proto_errs++;
      if (k == stall_word) begin
        held = out_var[sel];
        for (int s = 0; s < stall_cycles; s++) begin
          @(posedge clk); #1;
          if (out_var[sel] !== held || out_valid[sel] !== 1'b1) stall_changes++;
        end
      end
      res[k] = out_var[sel];
      out_ready[sel] = 1'b1;
      @(posedge clk); #1;
      out_ready[sel] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_valid[s] = 1'b0; in_var[s] = 32'h0; in_w[s] = '0; out_ready[s] = 1'b0;
    end
    #2 reset = 1'b0;
    #20;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({in_ready[s], w_ready[s], out_valid[s], busy[s]} !== 4'b0000 || out_var[s] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d got rdy=%b wr=%b ov=%b busy=%b out=%h exp all zero",
                 s, in_ready[s], w_ready[s], out_valid[s], busy[s], out_var[s]);
      end
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (in_ready[s] !== 1'b1 || busy[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release dut%0d got in_ready=%b busy=%b exp 1 0", s, in_ready[s], busy[s]);
      end
    end
  endtask

  task automatic test_single_round();
    logic [31:0] iv[8], w[64], res[8];
    int rc, pe, sc, to;
    for (int i = 0; i < 8; i++) iv[i] = IV[i];
    for (int t = 0; t < 64; t++) w[t] = $urandom;
    w[0] = 32'h61626380;
    run_block(3, iv, w, 0, -1, 0, 0, res, rc, pe, sc, to);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (res[k] !== ONE_ROUND[k]) begin
        errors++;
        $display("FAIL single_round word%0d got=%h exp=%h", k, res[k], ONE_ROUND[k]);
      end
    end
    checks++;
    if (rc != 1 || to != 0 || pe != 0) begin
      errors++;
      $display("FAIL single_round_latency got run=%0d to=%0d proto=%0d exp 1 0 0", rc, to, pe);
    end
  endtask

  task automatic test_abc_unroll();
    logic [31:0] iv[8], w[64], res[8];
    int rc, pe, sc, to;
    for (int i = 0; i < 8; i++) iv[i] = IV[i];
    abc_sched(w);
    for (int s = 0; s < 3; s++) begin
      run_block(s, iv, w, 0, -1, 0, 0, res, rc, pe, sc, to);
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (res[k] !== ABC_DIGEST[k]) begin
          errors++;
          $display("FAIL abc_u%0d word%0d got=%h exp=%h", CFG_UNROLL[s], k, res[k], ABC_DIGEST[k]);
        end
      end
      checks++;
      if (rc != 64 / CFG_UNROLL[s] || to != 0 || pe != 0) begin
        errors++;
        $display("FAIL abc_u%0d_latency got run=%0d to=%0d proto=%0d exp %0d 0 0",
                 CFG_UNROLL[s], rc, to, pe, 64 / CFG_UNROLL[s]);
      end
      checks++;
      if (in_ready[s] !== 1'b1 || out_valid[s] !== 1'b0 || busy[s] !== 1'b0) begin
        errors++;
        $display("FAIL abc_u%0d_return got rdy=%b ov=%b busy=%b exp 1 0 0",
                 CFG_UNROLL[s], in_ready[s], out_valid[s], busy[s]);
      end
    end
  endtask

  task automatic test_load_gaps();
    logic [31:0] iv[8], w[64], res[8];
    int rc, pe, sc, to;
    for (int i = 0; i < 8; i++) iv[i] = IV[i];
    abc_sched(w);
    run_block(0, iv, w, 3, -1, 0, 0, res, rc, pe, sc, to);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (res[k] !== ABC_DIGEST[k]) begin
        errors++;
        $display("FAIL load_gaps word%0d got=%h exp=%h", k, res[k], ABC_DIGEST[k]);
      end
    end
    checks++;
    if (pe != 0 || to != 0) begin
      errors++;
      $display("FAIL load_gaps_ready got proto=%0d to=%0d exp 0 0", pe, to);
    end
  endtask

  task automatic test_out_stall();
    logic [31:0] iv[8], w[64], res[8];
    int rc, pe, sc, to;
    for (int i = 0; i < 8; i++) iv[i] = IV[i];
    abc_sched(w);
    run_block(0, iv, w, 0, 2, 5, 0, res, rc, pe, sc, to);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (res[k] !== ABC_DIGEST[k]) begin
        errors++;
        $display("FAIL out_stall word%0d got=%h exp=%h", k, res[k], ABC_DIGEST[k]);
      end
    end
    checks++;
    if (sc != 0 || to != 0) begin
      errors++;
      $display("FAIL out_stall_hold got changes=%0d to=%0d exp 0 0", sc, to);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] iv[8], w[64], res[8];
    int rc, pe, sc, to;
    for (int i = 0; i < 8; i++) iv[i] = IV[i];
    abc_sched(w);
    run_block(0, iv, w, 0, -1, 0, 20, res, rc, pe, sc, to);
    checks++;
    if (rc != 20 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_reach got run=%0d busy=%b exp 20 1", rc, busy[0]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready[0], w_ready[0], out_valid[0], busy[0]} !== 4'b0000 || out_var[0] !== 32'h0) begin
      errors++;
      $display("FAIL mid_run_reset got rdy=%b wr=%b ov=%b busy=%b out=%h exp all zero",
               in_ready[0], w_ready[0], out_valid[0], busy[0], out_var[0]);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_release got in_ready=%b exp 1", in_ready[0]);
    end
    run_block(0, iv, w, 0, -1, 0, 0, res, rc, pe, sc, to);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (res[k] !== ABC_DIGEST[k]) begin
        errors++;
        $display("FAIL mid_run_fresh word%0d got=%h exp=%h", k, res[k], ABC_DIGEST[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] iv[8], w[64], res[8], exp_res[8];
    int rc, pe, sc, to;
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) iv[i] = $urandom;
        for (int t = 0; t < 64; t++) w[t] = $urandom;
        ref_compress(iv, w, CFG_ROUNDS[s], CFG_FF[s], exp_res);
        run_block(s, iv, w, $urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 3), 0,
                  res, rc, pe, sc, to);
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (res[k] !== exp_res[k]) begin
            errors++;
            $display("FAIL random_dut%0d_blk%0d word%0d got=%h exp=%h", s, b, k, res[k], exp_res[k]);
          end
        end
        checks++;
        if (rc != CFG_ROUNDS[s] / CFG_UNROLL[s] || pe != 0 || sc != 0 || to != 0) begin
          errors++;
          $display("FAIL random_dut%0d_blk%0d_proto got run=%0d proto=%0d stall=%0d to=%0d exp %0d 0 0 0",
                   s, b, rc, pe, sc, to, CFG_ROUNDS[s] / CFG_UNROLL[s]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_round();
    test_abc_unroll();
    test_load_gaps();
    test_out_stall();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
